// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed FIR: one signed MAC steps through NTAPS programmable taps over a
// circular sample buffer, then holds a floor-shifted, saturated result on a valid/ready port.
module fir_mac_sequencer #(
  parameter int NTAPS  = 9,
  parameter int SHIFT  = 15,
  parameter int DATA_W = 16,
  parameter int COEF_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] out_data,
  input  logic                     out_ready,
  input  logic                     cfg_we,
  input  logic [3:0]               cfg_addr,
  input  logic signed [COEF_W-1:0] cfg_data,
  output logic                     cfg_err,
  output logic                     busy
);

  localparam int PW     = (NTAPS > 1) ? $clog2(NTAPS) : 1;
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = PROD_W + 4;
  localparam logic [PW-1:0] LAST     = PW'(NTAPS - 1);
  localparam logic [3:0]    ADDR_MAX = 4'(NTAPS - 1);
  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((1 <<< (DATA_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_LO = ~SAT_HI;

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_DONE} state_t;

  state_t r_state, w_state_nxt;

  logic signed [DATA_W-1:0] r_buf  [NTAPS];
  logic signed [COEF_W-1:0] r_coef [NTAPS];
  logic [PW-1:0]            r_wp, r_base, r_tap;
  logic signed [PROD_W-1:0] r_prod_p0;
  logic                     r_vld_p0;
  logic signed [ACC_W-1:0]  r_acc_p1;
  logic signed [DATA_W-1:0] r_out_data;
  logic                     r_out_vld;
  logic                     r_cfg_err;

  logic [PW-1:0]            w_idx, w_caddr;
  logic signed [PROD_W-1:0] w_prod;
  logic signed [ACC_W-1:0]  w_prod_ext, w_sum;
  logic                     w_accept, w_last, w_cfg_ok;

  function automatic logic signed [COEF_W-1:0] default_coef(input int k);
    case (k)
      0, 8:    return COEF_W'(16'h04F6);
      1, 7:    return COEF_W'(16'h0AE1);
      2, 6:    return COEF_W'(16'h1089);
      3, 5:    return COEF_W'(16'h1496);
      4:       return COEF_W'(16'h160F);
      default: return '0;
    endcase
  endfunction

  // Floor shift (arithmetic >>> truncates toward -inf), then clamp to the output range.
  function automatic logic signed [DATA_W-1:0] shift_sat(input logic signed [ACC_W-1:0] v);
    logic signed [ACC_W-1:0] s;
    s = v >>> SHIFT;
    if (s > SAT_HI)      s = SAT_HI;
    else if (s < SAT_LO) s = SAT_LO;
    return s[DATA_W-1:0];
  endfunction

  assign w_accept = in_valid && (r_state == S_IDLE);
  assign w_last   = (r_tap == LAST);
  assign w_cfg_ok = cfg_we && (r_state == S_IDLE) && (cfg_addr <= ADDR_MAX);
  assign w_caddr  = PW'(cfg_addr);

  always_comb begin
    if (r_base >= r_tap) w_idx = r_base - r_tap;
    else                 w_idx = r_base + PW'(NTAPS) - r_tap;
  end

  assign w_prod     = r_buf[w_idx] * r_coef[r_tap];
  assign w_prod_ext = {{(ACC_W - PROD_W){r_prod_p0[PROD_W-1]}}, r_prod_p0};
  assign w_sum      = r_acc_p1 + w_prod_ext;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    busy        = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = S_MAC;
      end
      S_MAC: begin
        busy = 1'b1;
        if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        busy = 1'b1;
        if (r_out_vld && out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NTAPS; i++) begin
        r_buf[i]  <= '0;
        r_coef[i] <= default_coef(i);
      end
      r_wp       <= '0;
      r_base     <= '0;
      r_tap      <= '0;
      r_prod_p0  <= '0;
      r_vld_p0   <= 1'b0;
      r_acc_p1   <= '0;
      r_out_data <= '0;
      r_out_vld  <= 1'b0;
      r_cfg_err  <= 1'b0;
    end else begin
      r_cfg_err <= cfg_we && !w_cfg_ok;
      if (w_cfg_ok) r_coef[w_caddr] <= cfg_data;

      // p0: product of the current tap, registered.
      r_prod_p0 <= w_prod;
      r_vld_p0  <= (r_state == S_MAC);

      // p1: accumulate; the last product is folded in directly at the output stage.
      if (w_accept) begin
        r_buf[r_wp] <= in_data;
        r_base      <= r_wp;
        r_wp        <= (r_wp == LAST) ? '0 : r_wp + 1'b1;
        r_acc_p1    <= '0;
        r_tap       <= '0;
      end else if (r_state == S_MAC) begin
        if (!w_last)  r_tap    <= r_tap + 1'b1;
        if (r_vld_p0) r_acc_p1 <= w_sum;
      end

      // p2: result register, held until the downstream handshake.
      if ((r_state == S_DONE) && r_vld_p0) begin
        r_out_data <= shift_sat(w_sum);
        r_out_vld  <= 1'b1;
      end else if (r_out_vld && out_ready) begin
        r_out_vld <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_vld;
  assign out_data  = r_out_data;
  assign cfg_err   = r_cfg_err;

endmodule
